// File: rtl/alu.sv
// Registered 64-bit RV64I R-type ALU: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
// Define ALU_FLAGS_EN to drive status flags on Cout; otherwise Cout is tied to 0.
module alu (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [63:0] rs1,
  input  logic signed [63:0] rs2,
  input  logic        [2:0]  func3,
  input  logic        [6:0]  func7,
  output logic signed [63:0] out,
  output logic signed [9:0]  Cout
);

  logic        w_isAddSub;
  logic        w_isSub;
  logic [63:0] w_opB;
  logic [63:0] w_sum;
  logic        w_carry;
  logic [5:0]  w_shamt;
  logic [63:0] w_result;
  logic [9:0]  w_flags;
  logic [63:0] r_out;
  logic [9:0]  r_flags;

  // Subtract shares the adder as rs1 + ~rs2 + 1 so carry/overflow come from one place.
  assign w_isAddSub       = (func3 == 3'd0);
  assign w_isSub          = w_isAddSub && func7[5];
  assign w_opB            = w_isSub ? ~rs2 : rs2;
  assign {w_carry, w_sum} = {1'b0, rs1} + {1'b0, w_opB} + {64'd0, w_isSub};
  assign w_shamt          = rs2[5:0];

  always_comb begin
    w_result = 64'd0;
    case (func3)
      3'd0: w_result = w_sum;
      3'd1: w_result = rs1 << w_shamt;
      3'd2: w_result = {63'd0, ($signed(rs1) < $signed(rs2))};
      3'd3: w_result = {63'd0, ($unsigned(rs1) < $unsigned(rs2))};
      3'd4: w_result = rs1 ^ rs2;
      3'd5: w_result = func7[5] ? 64'($signed(rs1) >>> w_shamt)
                                : 64'($unsigned(rs1) >> w_shamt);
      3'd6: w_result = rs1 | rs2;
      3'd7: w_result = rs1 & rs2;
      default: w_result = 64'd0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  always_comb begin
    w_flags    = 10'd0;
    w_flags[0] = w_isAddSub && w_carry;
    w_flags[1] = w_isAddSub && (rs1[63] == w_opB[63]) && (w_sum[63] != rs1[63]);
    w_flags[2] = (w_result == 64'd0);
    w_flags[3] = w_result[63];
  end
`else
  assign w_flags = 10'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= 64'd0;
      r_flags <= 10'd0;
    end else begin
      r_out   <= w_result;
      r_flags <= w_flags;
    end
  end

  assign out  = r_out;
  assign Cout = r_flags;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; flag expectations follow ALU_FLAGS_EN.
module tb_alu;

  logic               clk;
  logic               rst_n;
  logic signed [63:0] rs1;
  logic signed [63:0] rs2;
  logic        [2:0]  func3;
  logic        [6:0]  func7;
  logic signed [63:0] out;
  logic signed [9:0]  Cout;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] F7_NORM = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs1   (rs1),
    .rs2   (rs2),
    .func3 (func3),
    .func7 (func7),
    .out   (out),
    .Cout  (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation at the falling edge, let it be captured, settle past the edge.
  task automatic drive(input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    rs1 = a; rs2 = b; func3 = f3; func7 = f7;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rs1 = 64'd0; rs2 = 64'd0; func3 = 3'd0; func7 = F7_NORM;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 64'd0 || Cout !== 10'd0) begin
      failures++;
      $display("[TB] FAIL reset_initial out=%h Cout=%h expected 0/0", out, Cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(64'd7, 64'd9, 3'd0, F7_NORM);
    checks++;
    if (out !== 64'd16) begin
      failures++;
      $display("[TB] FAIL first_capture out=%0d expected 16", out);
    end
    // Mid-cycle reset must clear immediately without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 64'd0 || Cout !== 10'd0) begin
      failures++;
      $display("[TB] FAIL reset_async out=%h Cout=%h expected 0/0", out, Cout);
    end
    drive(64'd5, 64'd5, 3'd6, F7_NORM);
    checks++;
    if (out !== 64'd0) begin
      failures++;
      $display("[TB] FAIL reset_hold out=%h expected 0", out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_sub;
    logic [63:0] va [6];
    logic [63:0] vb [6];
    logic [6:0]  vf [6];
    logic [63:0] ve [6];
    va = '{64'd7, 64'd7, -64'sd7, 64'd9, 64'd7, 64'd7};
    vb = '{64'd9, -64'sd9, 64'd9, 64'd7, 64'd9, -64'sd9};
    vf = '{F7_NORM, F7_NORM, F7_NORM, F7_ALT, F7_ALT, F7_ALT};
    ve = '{64'd16, -64'sd2, 64'd2, 64'd2, -64'sd2, 64'd16};
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], 3'd0, vf[i]);
      checks++;
      if (out !== ve[i]) begin
        failures++;
        $display("[TB] FAIL add_sub[%0d] out=%0d expected %0d", i, out, $signed(ve[i]));
      end
    end
  endtask

  task automatic test_flags;
    logic [9:0] expOvf;
    logic [9:0] expZero;
    logic [9:0] expNeg;
    logic [9:0] expXorZ;
`ifdef ALU_FLAGS_EN
    expOvf  = 10'h00A;
    expZero = 10'h005;
    expNeg  = 10'h008;
    expXorZ = 10'h004;
`else
    expOvf  = 10'h000;
    expZero = 10'h000;
    expNeg  = 10'h000;
    expXorZ = 10'h000;
`endif
    drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'd0, F7_NORM);
    checks++;
    if (out !== 64'h8000_0000_0000_0000 || Cout !== expOvf) begin
      failures++;
      $display("[TB] FAIL flags_overflow out=%h Cout=%h expected %h/%h",
               out, Cout, 64'h8000_0000_0000_0000, expOvf);
    end
    drive(64'd5, 64'd5, 3'd0, F7_ALT);
    checks++;
    if (out !== 64'd0 || Cout !== expZero) begin
      failures++;
      $display("[TB] FAIL flags_sub_zero out=%h Cout=%h expected 0/%h", out, Cout, expZero);
    end
    drive(-64'sd10, 64'd2, 3'd1, F7_NORM);
    checks++;
    if (out !== -64'sd40 || Cout !== expNeg) begin
      failures++;
      $display("[TB] FAIL flags_sll_neg out=%h Cout=%h expected -40/%h", out, Cout, expNeg);
    end
    drive(64'd7, 64'd7, 3'd4, F7_NORM);
    checks++;
    if (out !== 64'd0 || Cout !== expXorZ) begin
      failures++;
      $display("[TB] FAIL flags_xor_zero out=%h Cout=%h expected 0/%h", out, Cout, expXorZ);
    end
  endtask

  task automatic test_shifts;
    logic [63:0] va [9];
    logic [63:0] vb [9];
    logic [2:0]  vo [9];
    logic [6:0]  vf [9];
    logic [63:0] ve [9];
    va = '{64'd10, -64'sd10, 64'd16, -64'sd16, 64'd16, 64'd16, -64'sd16, 64'd16, -64'sd16};
    vb = '{64'd2, 64'd2, 64'd2, 64'd2, 64'd20, 64'd2, 64'd2, 64'd20, 64'd20};
    vo = '{3'd1, 3'd1, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5};
    vf = '{F7_NORM, F7_NORM, F7_NORM, F7_NORM, F7_NORM, F7_ALT, F7_ALT, F7_ALT, F7_ALT};
    ve = '{64'd40, -64'sd40, 64'd4, 64'h3FFF_FFFF_FFFF_FFFC, 64'd0,
           64'd4, -64'sd4, 64'd0, -64'sd1};
    for (int i = 0; i < 9; i++) begin
      drive(va[i], vb[i], vo[i], vf[i]);
      checks++;
      if (out !== ve[i]) begin
        failures++;
        $display("[TB] FAIL shift[%0d] out=%h expected %h", i, out, ve[i]);
      end
    end
  endtask

  task automatic test_compares;
    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic [63:0] eSlt [4];
    logic [63:0] eSltu [4];
    va    = '{-64'sd7, 64'd7, 64'd9, 64'd9};
    vb    = '{64'd9, 64'd9, 64'd7, -64'sd7};
    eSlt  = '{64'd1, 64'd1, 64'd0, 64'd0};
    eSltu = '{64'd0, 64'd1, 64'd0, 64'd1};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], 3'd2, F7_NORM);
      checks++;
      if (out !== eSlt[i]) begin
        failures++;
        $display("[TB] FAIL slt[%0d] out=%0d expected %0d", i, out, eSlt[i]);
      end
      drive(va[i], vb[i], 3'd3, F7_NORM);
      checks++;
      if (out !== eSltu[i]) begin
        failures++;
        $display("[TB] FAIL sltu[%0d] out=%0d expected %0d", i, out, eSltu[i]);
      end
    end
  endtask

  task automatic test_logic;
    logic [63:0] va [9];
    logic [63:0] vb [9];
    logic [2:0]  vo [9];
    logic [63:0] ve [9];
    va = '{64'd7, 64'd7, 64'd0, 64'd7, 64'd7, 64'd7, 64'd7, 64'd7, 64'd7};
    vb = '{64'd9, 64'd7, 64'd7, 64'd9, 64'd7, 64'd0, 64'd9, 64'd7, 64'd0};
    vo = '{3'd4, 3'd4, 3'd4, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7};
    ve = '{64'd14, 64'd0, 64'd7, 64'd15, 64'd7, 64'd7, 64'd1, 64'd7, 64'd0};
    for (int i = 0; i < 9; i++) begin
      drive(va[i], vb[i], vo[i], F7_NORM);
      checks++;
      if (out !== ve[i]) begin
        failures++;
        $display("[TB] FAIL logic[%0d] out=%0d expected %0d", i, out, ve[i]);
      end
    end
  endtask

  task automatic test_decode_corners;
    drive(64'd7, 64'd9, 3'd4, F7_ALT);
    checks++;
    if (out !== 64'd14) begin
      failures++;
      $display("[TB] FAIL xor_f7alt out=%0d expected 14", out);
    end
    drive(-64'sd7, 64'd9, 3'd2, F7_ALT);
    checks++;
    if (out !== 64'd1) begin
      failures++;
      $display("[TB] FAIL slt_f7alt out=%0d expected 1", out);
    end
    drive(64'd7, 64'd9, 3'd0, 7'h5F);
    checks++;
    if (out !== 64'd16) begin
      failures++;
      $display("[TB] FAIL add_f7other out=%0d expected 16", out);
    end
    drive(64'd10, 64'd66, 3'd1, F7_NORM);
    checks++;
    if (out !== 64'd40) begin
      failures++;
      $display("[TB] FAIL sll_by66 out=%0d expected 40", out);
    end
    drive(-64'sd16, 64'd66, 3'd5, F7_ALT);
    checks++;
    if (out !== -64'sd4) begin
      failures++;
      $display("[TB] FAIL sra_by66 out=%0d expected -4", out);
    end
    drive(64'h8000_0000_0000_0001, 64'd0, 3'd5, F7_ALT);
    checks++;
    if (out !== 64'h8000_0000_0000_0001) begin
      failures++;
      $display("[TB] FAIL sra_by0 out=%h expected 8000000000000001", out);
    end
  endtask

  task automatic test_back_to_back;
    drive(64'd3, 64'd4, 3'd0, F7_NORM);
    // Inputs wiggling between edges must not reach the output.
    rs1 = 64'd100; rs2 = 64'd200; func3 = 3'd6;
    #3;
    checks++;
    if (out !== 64'd7) begin
      failures++;
      $display("[TB] FAIL hold_between_edges out=%0d expected 7", out);
    end
    @(negedge clk);
    rs1 = 64'd12; rs2 = 64'd10; func3 = 3'd7; func7 = F7_NORM;
    @(posedge clk); #1;
    checks++;
    if (out !== 64'd8) begin
      failures++;
      $display("[TB] FAIL b2b_and out=%0d expected 8", out);
    end
    rs1 = 64'd12; rs2 = 64'd10; func3 = 3'd0; func7 = F7_ALT;
    @(posedge clk); #1;
    checks++;
    if (out !== 64'd2) begin
      failures++;
      $display("[TB] FAIL b2b_sub out=%0d expected 2", out);
    end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_flags;
    test_shifts;
    test_compares;
    test_logic;
    test_decode_corners;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 64-bit RV64I integer ALU for the execute stage of the sequential RISC-V core. It decodes the R-type `func3`/`func7` fields and computes ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR and AND on two signed 64-bit operands. The result and an optional status-flag vector are registered once per clock and feed the write-back path.

## Interface
Parameters: none. Width is fixed at 64 bits.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- rs1  input  64  operand A, signed two's complement
- rs2  input  64  operand B, signed two's complement; bits [5:0] are the shift amount
- func3  input  3  operation select
- func7  input  7  operation modifier; only bit 5 is decoded
- out  output  64  registered result, signed
- Cout  output  10  registered status flags, signed vector (see Configuration)

## Operation
- func3=0: `func7[5]=0` gives rs1+rs2; `func7[5]=1` gives rs1-rs2. Both are modulo 2^64, with wrap-around and no trap.
- func3=1: SLL gives rs1 << rs2[5:0], zero fill.
- func3=2: SLT gives 1 if $signed(rs1) < $signed(rs2), else 0. The result is zero-extended to 64 bits.
- func3=3: SLTU gives 1 if rs1 < rs2 as unsigned, else 0.
- func3=4: rs1 ^ rs2.
- func3=5: `func7[5]=0` gives SRL, rs1 >> rs2[5:0] with zero fill. `func7[5]=1` gives SRA, rs1 >>> rs2[5:0] with sign fill.
- func3=6: rs1 | rs2.
- func3=7: rs1 & rs2.
- `func7` bits other than bit 5 are ignored. `func7[5]` is ignored for func3 values other than 0 and 5.
- Shift amounts of 0 return rs1 unchanged. rs2[63:6] never affects a shift.
- Cout bit assignments:
  - [0] carry-out of the add/sub adder (subtract is rs1 + ~rs2 + 1)
  - [1] signed overflow of the add/sub
  - [2] zero: next out == 0
  - [3] negative: next out[63]
  - [9:4] always 0
- Bits [1:0] are computed only for func3=0 and are 0 for every other op.

## Timing
- Inputs are sampled on each rising clk edge. out and Cout update on that same edge, so latency is 1 cycle and throughput is one op per cycle. There is no handshake.
- Input changes between edges have no effect on the outputs.
- rst_n low forces out=0 and Cout=0 immediately, independent of clk. The registers hold 0 while reset is asserted.
- First capture is on the first rising edge after rst_n deasserts.
- If reset is asserted mid-stream, the in-flight result is discarded.

## Configuration
- Macro `ALU_FLAGS_EN`.
- Defined: Cout carries the flags exactly as described in Operation.
- Undefined: Cout is tied to 0, the flag logic is removed, and out behaviour is unchanged.

## Test plan
- Reset, add and sub
  - Stimulus: assert rst_n=0 mid-run, then release; then ADD 7+9, 7+(-9), -7+9; then SUB 9-7, 7-9, 7-(-9).
  - Response: out=0 and Cout=0 immediately on reset. Adds give out=16, -2, 2 one cycle later. Subs give out=2, -2, 16.
- Overflow and carry (ALU_FLAGS_EN defined)
  - Stimulus: ADD 0x7FFF_FFFF_FFFF_FFFF+1; then SUB 5-5.
  - Response: the add gives out=0x8000_0000_0000_0000 with Cout[1]=1 and Cout[3]=1. The sub gives out=0 with Cout[2]=1 and Cout[0]=1.
- Shifts
  - Stimulus: SLL 10<<2 and -10<<2; SRL 16>>2, -16>>2, 16>>20; SRA 16>>>2, -16>>>2, 16>>>20, -16>>>20.
  - Response: SLL gives 40 and -40. SRL gives 4, 0x3FFF_FFFF_FFFF_FFFC, 0. SRA gives 4, -4, 0, -1.
- Compares
  - Stimulus: SLT on (-7,9), (7,9), (9,7), (9,-7); SLTU on the same four pairs.
  - Response: SLT gives 1, 1, 0, 0. SLTU gives 0, 1, 0, 1.
- Logic
  - Stimulus: XOR (7,9), (7,7), (0,7); OR (7,9), (7,7), (7,0); AND (7,9), (7,7), (7,0).
  - Response: XOR gives 14, 0, 7. OR gives 15, 7, 7. AND gives 1, 7, 0.
- Decode corners
  - Stimulus: func7=0x20 with func3=4; shift by rs2=64+2.
  - Response: XOR result is unchanged. The shift behaves as a shift by 2.
